// File: rtl/display_page_scheduler_pkg.sv
// Shared types and helpers for the display page scheduler.
// Holds the scheduler state encoding, page geometry and small index helpers.
package display_page_scheduler_pkg;

    localparam int unsigned NUM_PAGES = 4;
    localparam int unsigned PAGE_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROTATE   = 2'd1,
        MANUAL   = 2'd2,
        OVERRIDE = 2'd3
    } state_t;

    // Lowest set bit wins, so scanning from the top leaves the lowest index last.
    function automatic logic [PAGE_W-1:0] lowest_set(input logic [NUM_PAGES-1:0] v);
        lowest_set = '0;
        for (int unsigned i = NUM_PAGES; i > 0; i--) begin
            if (v[i-1]) lowest_set = PAGE_W'(i - 1);
        end
    endfunction

    function automatic logic [NUM_PAGES-1:0] one_hot(input logic [PAGE_W-1:0] idx);
        one_hot      = '0;
        one_hot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/display_page_scheduler_page_next_finder.sv
// Finds the next valid page after cur, searching cur+1 .. cur+3 and finally cur itself.
module page_next_finder
    import display_page_scheduler_pkg::*;
(
    input  logic [PAGE_W-1:0]    cur,
    input  logic [NUM_PAGES-1:0] page_valid,
    output logic [PAGE_W-1:0]    next,
    output logic                 any_valid
);

    logic [PAGE_W-1:0] idx;
    logic              found;

    always_comb begin
        next      = cur;
        any_valid = |page_valid;
        idx       = cur;
        found     = 1'b0;
        for (int unsigned k = 1; k <= NUM_PAGES; k++) begin
            idx = PAGE_W'(32'(cur) + k);
            if (!found && page_valid[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_page_scheduler.sv
// Selects the page shown on the multiplexed display: timed rotation, manual
// stepping and fixed-priority override requests with a minimum hold time.
module display_page_scheduler
    import display_page_scheduler_pkg::*;
#(
    parameter int unsigned DWELL_MS = 2000,
    parameter int unsigned HOLD_MS  = 5000
) (
    input  logic                 clk_50mhz,
    input  logic                 rst,
    input  logic                 tick_1khz,
    input  logic                 auto_en,
    input  logic                 btn_next,
    input  logic [NUM_PAGES-1:0] page_valid,
    input  logic [NUM_PAGES-1:0] req,
    output logic [PAGE_W-1:0]    mode,
    output logic [NUM_PAGES-1:0] page_active,
    output logic                 blank,
    output logic                 override
);

    localparam int unsigned CNT_MAX = (DWELL_MS > HOLD_MS) ? DWELL_MS : HOLD_MS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, state_n, run_state;
    logic [PAGE_W-1:0] mode_n, saved_page, saved_n;
    logic [PAGE_W-1:0] cur_next, saved_next;
    logic              cur_any, saved_any;
    logic              blank_n, override_n;
    logic [CNT_W-1:0]  ms_cnt, ms_n, ms_inc;
    logic              dwell_done;

    page_next_finder u_cur_next (
        .cur        (mode),
        .page_valid (page_valid),
        .next       (cur_next),
        .any_valid  (cur_any)
    );

    page_next_finder u_saved_next (
        .cur        (saved_page),
        .page_valid (page_valid),
        .next       (saved_next),
        .any_valid  (saved_any)
    );

    assign run_state  = auto_en ? ROTATE : MANUAL;
    // Saturating so a long stay in MANUAL or IDLE cannot wrap the counter.
    assign ms_inc     = (tick_1khz && ms_cnt != CNT_W'(CNT_MAX)) ? ms_cnt + 1'b1 : ms_cnt;
    assign dwell_done = tick_1khz && (ms_cnt == CNT_W'(DWELL_MS - 1));

    always_comb begin
        state_n    = state;
        mode_n     = mode;
        saved_n    = saved_page;
        blank_n    = blank;
        override_n = override;
        ms_n       = ms_inc;

        if (req != '0) begin
            // Overrides beat any simultaneous dwell expiry or button press.
            state_n    = OVERRIDE;
            mode_n     = lowest_set(req);
            ms_n       = '0;
            blank_n    = 1'b0;
            override_n = 1'b1;
            if (state != OVERRIDE) saved_n = mode;
        end else begin
            case (state)
                IDLE: begin
                    if (cur_any) begin
                        state_n = run_state;
                        mode_n  = cur_next;
                        blank_n = 1'b0;
                        ms_n    = '0;
                    end
                end
                ROTATE, MANUAL: begin
                    if (!cur_any) begin
                        state_n = IDLE;
                        blank_n = 1'b1;
                        ms_n    = '0;
                    end else if (!page_valid[mode]) begin
                        state_n = run_state;
                        mode_n  = cur_next;
                        ms_n    = '0;
                    end else if (state != run_state) begin
                        state_n = run_state;
                        ms_n    = '0;
                    end else if (btn_next || (state == ROTATE && dwell_done)) begin
                        mode_n = cur_next;
                        ms_n   = '0;
                    end
                end
                OVERRIDE: begin
                    if (ms_cnt == CNT_W'(HOLD_MS)) begin
                        override_n = 1'b0;
                        ms_n       = '0;
                        if (!saved_any) begin
                            state_n = IDLE;
                            blank_n = 1'b1;
                        end else begin
                            state_n = run_state;
                            blank_n = 1'b0;
                            mode_n  = page_valid[saved_page] ? saved_page : saved_next;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= '0;
            page_active <= NUM_PAGES'(1);
            blank       <= 1'b1;
            override    <= 1'b0;
            ms_cnt      <= '0;
            saved_page  <= '0;
        end else begin
            state       <= state_n;
            mode        <= mode_n;
            page_active <= one_hot(mode_n);
            blank       <= blank_n;
            override    <= override_n;
            ms_cnt      <= ms_n;
            saved_page  <= saved_n;
        end
    end

endmodule

// File: tb/tb_display_page_scheduler.sv
// Bench for display_page_scheduler: directed vector table, async reset sequence,
// then randomized traffic against a behavioural page-selection model.
module tb_display_page_scheduler;

    localparam int DWELL = 3;
    localparam int HOLD  = 2;

    logic       clk_50mhz = 1'b0;
    logic       rst;
    logic       tick_1khz, auto_en, btn_next;
    logic [3:0] page_valid, req;
    logic [1:0] mode;
    logic [3:0] page_active;
    logic       blank, override;

    int tests = 0;
    int fails = 0;

    display_page_scheduler #(.DWELL_MS(DWELL), .HOLD_MS(HOLD)) dut (
        .clk_50mhz   (clk_50mhz),
        .rst         (rst),
        .tick_1khz   (tick_1khz),
        .auto_en     (auto_en),
        .btn_next    (btn_next),
        .page_valid  (page_valid),
        .req         (req),
        .mode        (mode),
        .page_active (page_active),
        .blank       (blank),
        .override    (override)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int e_mode, input bit e_blank, input bit e_ovr);
        logic [3:0] e_act;
        e_act = 4'b0001 << e_mode;
        chk({name, ".mode"}, int'(mode), e_mode);
        chk({name, ".page_active"}, int'(page_active), int'(e_act));
        chk({name, ".blank"}, int'(blank), int'(e_blank));
        chk({name, ".override"}, int'(override), int'(e_ovr));
    endtask

    // Reference model: tracks what is on screen, not how the RTL encodes it.
    int m_mode, m_saved, m_ms;
    bit m_shown, m_ovr, m_manual;

    function automatic int nv(input int cur, input logic [3:0] pv);
        for (int k = 1; k <= 4; k++) begin
            if (pv[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_saved = 0; m_ms = 0;
        m_shown = 0; m_ovr = 0; m_manual = 0;
    endtask

    task automatic model_step();
        if (req != 0) begin
            if (!m_ovr) m_saved = m_mode;
            m_ovr = 1; m_shown = 1; m_mode = lowest(req); m_ms = 0;
        end else if (m_ovr) begin
            if (m_ms == HOLD) begin
                m_ovr = 0; m_ms = 0;
                if (page_valid == 0) m_shown = 0;
                else begin
                    m_shown  = 1;
                    m_manual = !auto_en;
                    m_mode   = page_valid[m_saved] ? m_saved : nv(m_saved, page_valid);
                end
            end else if (tick_1khz) m_ms++;
        end else if (!m_shown) begin
            if (page_valid != 0) begin
                m_shown = 1; m_manual = !auto_en; m_mode = nv(m_mode, page_valid); m_ms = 0;
            end
        end else if (page_valid == 0) begin
            m_shown = 0; m_ms = 0;
        end else if (!page_valid[m_mode]) begin
            m_mode = nv(m_mode, page_valid); m_manual = !auto_en; m_ms = 0;
        end else if (m_manual == auto_en) begin
            m_manual = !auto_en; m_ms = 0;
        end else if (btn_next || (!m_manual && tick_1khz && m_ms == DWELL - 1)) begin
            m_mode = nv(m_mode, page_valid); m_ms = 0;
        end else if (tick_1khz) m_ms++;
    endtask

    typedef struct {
        int         rep;
        bit         a;
        bit         b;
        bit         t;
        logic [3:0] pv;
        logic [3:0] rq;
        int         e_mode;
        bit         e_blank;
        bit         e_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic cycle(input bit a, input bit b, input bit t, input logic [3:0] pv, input logic [3:0] rq);
        auto_en = a; btn_next = b; tick_1khz = t; page_valid = pv; req = rq;
        @(posedge clk_50mhz);
        #1;
    endtask

    initial begin
        logic [7:0] got, exp;
        logic [3:0] e_act;

        rst = 1'b1; tick_1khz = 0; auto_en = 0; btn_next = 0; page_valid = 0; req = 0;
        #2;
        chk_out("reset", 0, 1'b1, 1'b0);
        @(posedge clk_50mhz); #1;
        rst = 1'b0;

        // rep, auto, btn, tick, page_valid, req -> mode, blank, override
        tbl.push_back('{1, 1, 0, 0, 4'b1011, 4'b0000, 1, 0, 0});
        tbl.push_back('{2, 1, 0, 1, 4'b1011, 4'b0000, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4'b1011, 4'b0000, 3, 0, 0});
        tbl.push_back('{2, 1, 0, 1, 4'b1011, 4'b0000, 3, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4'b1011, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 4'b1111, 4'b0000, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 4'b1111, 4'b0000, 2, 0, 0});
        tbl.push_back('{10, 0, 0, 1, 4'b1111, 4'b0000, 2, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 4'b1111, 4'b0000, 3, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 4'b1111, 4'b0000, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b1100, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b1110, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 1});
        tbl.push_back('{2, 1, 0, 1, 4'b1111, 4'b0000, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 0});
        tbl.push_back('{2, 1, 0, 1, 4'b1111, 4'b0000, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4'b1111, 4'b0000, 2, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 4'b1111, 4'b0000, 3, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0001, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b0011, 4'b0001, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b0011, 4'b0000, 0, 0, 1});
        tbl.push_back('{2, 1, 0, 1, 4'b0011, 4'b0000, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b0011, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{2, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 4'b1111, 4'b0100, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 2, 0, 1});
        tbl.push_back('{2, 1, 0, 1, 4'b1111, 4'b0000, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{2, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4'b1111, 4'b0000, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 0});

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++)
                cycle(tbl[i].a, tbl[i].b, tbl[i].t, tbl[i].pv, tbl[i].rq);
            chk_out($sformatf("vec%0d", i), tbl[i].e_mode, tbl[i].e_blank, tbl[i].e_ovr);
        end

        // Asynchronous reset in the middle of an override hold.
        cycle(1, 0, 0, 4'b1111, 4'b0010);
        chk_out("async.pre_ovr", 1, 1'b0, 1'b1);
        cycle(1, 0, 1, 4'b1111, 4'b0000);
        chk_out("async.mid_hold", 1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async.rst", 0, 1'b1, 1'b0);
        tick_1khz = 0; btn_next = 0; req = 0; page_valid = 0; auto_en = 1;
        @(posedge clk_50mhz); #1;
        rst = 1'b0;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            tick_1khz = ($urandom_range(0, 1) == 0);
            btn_next  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) auto_en = !auto_en;
            if ($urandom_range(0, 19) == 0) page_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0)
                req = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            @(posedge clk_50mhz); #1;
            model_step();
            e_act = 4'b0001 << m_mode;
            got = {mode, page_active, blank, override};
            exp = {2'(m_mode), e_act, !m_shown, m_ovr};
            chk($sformatf("rand%0d {mode,active,blank,ovr}", c), int'(got), int'(exp));
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                chk($sformatf("rand%0d async_rst", c), int'({mode, page_active, blank, override}), int'(8'b00_0001_1_0));
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
